// File: rtl/qe_input_decoder_if.sv
// Signal bundle between the encoder source mux and the quadrature input decoder.
// The decoder takes the slave side; whatever drives the encoder lines takes the master side.
interface qe_input_decoder_if;
    logic       quadA_in;
    logic       quadB_in;
    logic       quadI_in;
    logic       error_clear;
    logic       count_pulse;
    logic       direction;
    logic       index;
    logic       phase_error;
    logic [7:0] error_count;

    modport master (
        output quadA_in, quadB_in, quadI_in, error_clear,
        input  count_pulse, direction, index, phase_error, error_count
    );

    modport slave (
        input  quadA_in, quadB_in, quadI_in, error_clear,
        output count_pulse, direction, index, phase_error, error_count
    );
endinterface

// File: rtl/qe_input_decoder.sv
// Quadrature encoder front end: per-input glitch filters, 4x A/B decoding with
// direction, qualified index strobe and illegal-transition tracking.
module qe_input_decoder #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter bit          INDEX_GATED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    qe_input_decoder_if.slave    bus
);

    typedef enum logic {
        ST_DISARMED,
        ST_ARMED
    } arm_state_e;

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    arm_state_e state_q, state_d;

    logic [2:0] raw;
    logic [2:0] f_q, f_d;
    logic [7:0] ca_q, ca_d, cb_q, cb_d, ci_q, ci_d;

    logic [1:0] prev_ab_q, prev_ab_d;
    logic       prev_i_q, prev_i_d;
    logic       count_pulse_q, count_pulse_d;
    logic       direction_q, direction_d;
    logic       index_q, index_d;
    logic       phase_error_q, phase_error_d;
    logic [7:0] error_count_q, error_count_d;

    logic [1:0] ab_cur;
    logic [1:0] ab_diff;
    logic       step_fwd;

    assign raw = {bus.quadA_in, bus.quadB_in, bus.quadI_in};

    // Returns {next filtered bit, next counter}.
    function automatic logic [8:0] filt_step(input logic in_bit, input logic f, input logic [7:0] c);
        logic [8:0] r;
        if (in_bit == f) begin
            r = {f, 8'd0};
        end else if (c == CNT_LAST) begin
            r = {in_bit, 8'd0};
        end else begin
            r = {f, c + 8'd1};
        end
        return r;
    endfunction

    always_comb begin
        {f_d[2], ca_d} = filt_step(raw[2], f_q[2], ca_q);
        {f_d[1], cb_d} = filt_step(raw[1], f_q[1], cb_q);
        {f_d[0], ci_d} = filt_step(raw[0], f_q[0], ci_q);
    end

    assign ab_cur  = f_q[2:1];
    assign ab_diff = ab_cur ^ prev_ab_q;

    // A leads B: 00->10->11->01->00.
    always_comb begin
        step_fwd = 1'b0;
        unique case ({prev_ab_q, ab_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
            default:                                step_fwd = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        prev_ab_d     = ab_cur;
        prev_i_d      = f_q[0];
        count_pulse_d = 1'b0;
        direction_d   = direction_q;
        index_d       = 1'b0;
        phase_error_d = phase_error_q;
        error_count_d = error_count_q;

        unique case (state_q)
            ST_DISARMED: begin
                if (raw == f_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                unique case (ab_diff)
                    2'b01, 2'b10: begin
                        count_pulse_d = 1'b1;
                        direction_d   = step_fwd;
                    end
                    2'b11: begin
                        phase_error_d = 1'b1;
                        if (error_count_q != 8'hFF) begin
                            error_count_d = error_count_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
                if (f_q[0] && !prev_i_q && (!INDEX_GATED || ab_cur == 2'b11)) begin
                    index_d = 1'b1;
                end
            end
            default: state_d = ST_DISARMED;
        endcase

        if (bus.error_clear) begin
            phase_error_d = 1'b0;
            error_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_DISARMED;
            f_q           <= '0;
            ca_q          <= '0;
            cb_q          <= '0;
            ci_q          <= '0;
            prev_ab_q     <= '0;
            prev_i_q      <= 1'b0;
            count_pulse_q <= 1'b0;
            direction_q   <= 1'b0;
            index_q       <= 1'b0;
            phase_error_q <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            f_q           <= f_d;
            ca_q          <= ca_d;
            cb_q          <= cb_d;
            ci_q          <= ci_d;
            prev_ab_q     <= prev_ab_d;
            prev_i_q      <= prev_i_d;
            count_pulse_q <= count_pulse_d;
            direction_q   <= direction_d;
            index_q       <= index_d;
            phase_error_q <= phase_error_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.count_pulse = count_pulse_q;
    assign bus.direction   = direction_q;
    assign bus.index       = index_q;
    assign bus.phase_error = phase_error_q;
    assign bus.error_count = error_count_q;

endmodule

// File: tb/tb_qe_input_decoder.sv
// Bench for qe_input_decoder: gated and ungated index variants driven in parallel,
// strobes matched against an event scoreboard of expected cycle and direction.
module tb_qe_input_decoder;

    localparam int unsigned FLEN = 4;
    localparam int unsigned LAT  = FLEN + 1;

    typedef struct {
        int unsigned cyc;
        logic        dir;
    } ev_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    logic [1:0]  cur_ab;

    ev_t cp_q  [2][$];
    ev_t idx_q [2][$];

    qe_input_decoder_if ifg ();
    qe_input_decoder_if ifu ();

    qe_input_decoder #(.FILTER_LEN(FLEN), .INDEX_GATED(1'b1)) dut_g (
        .clk   (clk),
        .reset (reset),
        .bus   (ifg)
    );

    qe_input_decoder #(.FILTER_LEN(FLEN), .INDEX_GATED(1'b0)) dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic cp, input logic dir, input logic idx);
        ev_t e;
        if (cp) begin
            if (cp_q[d].size() == 0) begin
                check_eq($sformatf("cp_unexpected%0d", d), 1, 0);
            end else begin
                e = cp_q[d].pop_front();
                check_eq($sformatf("cp_cyc%0d", d), cyc, e.cyc);
                check_eq($sformatf("cp_dir%0d", d), dir, e.dir);
            end
        end
        if (idx) begin
            if (idx_q[d].size() == 0) begin
                check_eq($sformatf("idx_unexpected%0d", d), 1, 0);
            end else begin
                e = idx_q[d].pop_front();
                check_eq($sformatf("idx_cyc%0d", d), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, ifg.count_pulse, ifg.direction, ifg.index);
            mon(1, ifu.count_pulse, ifu.direction, ifu.index);
        end
    end

    task automatic drive(input logic [1:0] ab, input logic i);
        ifg.quadA_in = ab[1]; ifg.quadB_in = ab[0]; ifg.quadI_in = i;
        ifu.quadA_in = ab[1]; ifu.quadB_in = ab[0]; ifu.quadI_in = i;
        cur_ab = ab;
    endtask

    task automatic set_clear(input logic v);
        ifg.error_clear = v;
        ifu.error_clear = v;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Move A/B to a new state; a legal step queues one expected pulse per DUT.
    task automatic go_ab(input logic [1:0] ab, input int unsigned hold, input bit legal, input logic dir);
        ev_t e;
        drive(ab, ifg.quadI_in);
        if (legal) begin
            e.cyc = cyc + LAT;
            e.dir = dir;
            cp_q[0].push_back(e);
            cp_q[1].push_back(e);
        end
        wait_cycles(hold);
    endtask

    task automatic go_i(input logic i, input bit exp_g, input bit exp_u, input int unsigned hold);
        ev_t e;
        drive(cur_ab, i);
        e.cyc = cyc + LAT;
        e.dir = 1'b0;
        if (exp_g) idx_q[0].push_back(e);
        if (exp_u) idx_q[1].push_back(e);
        wait_cycles(hold);
    endtask

    task automatic check_err(input string tag, input logic pe, input logic [7:0] cnt);
        check_eq({tag, "_pe_g"}, ifg.phase_error, pe);
        check_eq({tag, "_cnt_g"}, ifg.error_count, cnt);
        check_eq({tag, "_pe_u"}, ifu.phase_error, pe);
        check_eq({tag, "_cnt_u"}, ifu.error_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        set_clear(1'b0);
        drive(2'b11, 1'b0);

        wait_cycles(3);
        check_eq("rst_cp",  ifg.count_pulse, 1'b0);
        check_eq("rst_dir", ifg.direction,   1'b0);
        check_eq("rst_idx", ifg.index,       1'b0);
        check_err("rst", 1'b0, 8'd0);

        // Inputs sit at 11 through reset release: no pulse and no error may appear.
        reset = 1'b0;
        wait_cycles(20);
        check_err("arm", 1'b0, 8'd0);

        go_ab(2'b01, 10, 1, 1'b1);
        go_ab(2'b00, 10, 1, 1'b1);
        go_ab(2'b10, 10, 1, 1'b1);
        go_ab(2'b11, 10, 1, 1'b1);
        check_eq("fwd_dir", ifg.direction, 1'b1);

        go_ab(2'b10, 10, 1, 1'b0);
        go_ab(2'b00, 10, 1, 1'b0);
        go_ab(2'b01, 10, 1, 1'b0);
        go_ab(2'b11, 10, 1, 1'b0);
        check_eq("rev_dir", ifu.direction, 1'b0);

        for (int k = 0; k < 3; k++) begin
            go_ab(2'b01, FLEN - 1, 0, 1'b0);
            go_ab(2'b11, 8, 0, 1'b0);
        end
        go_ab(2'b01, FLEN, 1, 1'b1);
        go_ab(2'b11, 12, 1, 1'b0);

        go_ab(2'b10, 10, 1, 1'b0);
        go_ab(2'b00, 10, 1, 1'b0);
        go_ab(2'b11, 10, 0, 1'b0);
        check_err("ill", 1'b1, 8'd1);
        check_eq("ill_dir", ifg.direction, 1'b0);

        for (int k = 0; k < 259; k++) begin
            go_ab(cur_ab ^ 2'b11, 6, 0, 1'b0);
        end
        check_err("sat", 1'b1, 8'd255);

        // Clear sampled on the same edge that registers the illegal step.
        go_ab(cur_ab ^ 2'b11, FLEN, 0, 1'b0);
        set_clear(1'b1);
        wait_cycles(1);
        set_clear(1'b0);
        check_err("clrwin", 1'b0, 8'd0);
        wait_cycles(5);
        check_err("clrhold", 1'b0, 8'd0);

        go_ab(cur_ab ^ 2'b11, 10, 0, 1'b0);
        check_err("post", 1'b1, 8'd1);
        set_clear(1'b1);
        wait_cycles(1);
        set_clear(1'b0);
        check_err("clr", 1'b0, 8'd0);

        go_ab(2'b10, 10, 1, 1'b1);
        go_i(1'b1, 0, 1, 10);
        go_i(1'b0, 0, 0, 10);
        go_ab(2'b11, 10, 1, 1'b1);
        go_i(1'b1, 1, 1, 10);
        go_i(1'b0, 0, 0, 10);

        wait_cycles(20);
        check_eq("cp_left_g",  cp_q[0].size(),  0);
        check_eq("cp_left_u",  cp_q[1].size(),  0);
        check_eq("idx_left_g", idx_q[0].size(), 0);
        check_eq("idx_left_u", idx_q[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
